fixed_att_input_fork: RTL and testbench



---
 rtl/fixed_att_input_fork.sv | 139 +++++++++++++
 tb/tb_fixed_att_input_fork.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_att_input_fork.sv
// fixed_att_input_fork
// Fans one activation tile stream out to the Q, K and V branches of the
// fixed attention block through a single shared circular buffer. Each branch
// keeps its own read pointer and occupancy count, so branches drain
// independently. An entry can only be overwritten once every branch has read
// it. Branch index 0 = Q, 1 = K, 2 = V.
module fixed_att_input_fork #(
    parameter int DATA_WIDTH     = 8,
    parameter int IN_PARALLELISM = 3,
    parameter int IN_SIZE        = 3,
    parameter int DEPTH          = 6,
    parameter int CNT_WIDTH      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] data_in [IN_PARALLELISM*IN_SIZE],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,

    output logic [DATA_WIDTH-1:0] data_out_q [IN_PARALLELISM*IN_SIZE],
    output logic                  data_out_q_valid,
    input  logic                  data_out_q_ready,

    output logic [DATA_WIDTH-1:0] data_out_k [IN_PARALLELISM*IN_SIZE],
    output logic                  data_out_k_valid,
    input  logic                  data_out_k_ready,

    output logic [DATA_WIDTH-1:0] data_out_v [IN_PARALLELISM*IN_SIZE],
    output logic                  data_out_v_valid,
    input  logic                  data_out_v_ready,

    output logic [CNT_WIDTH-1:0]  occupancy
);

    localparam int N_ELEM   = IN_PARALLELISM * IN_SIZE;
    localparam int N_BR     = 3;
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    // Pointer advance with explicit wrap, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH][N_ELEM];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q [N_BR];
    logic [PTR_W-1:0]      rd_ptr_d [N_BR];
    logic [CNT_WIDTH-1:0]  cnt_q    [N_BR];
    logic [CNT_WIDTH-1:0]  cnt_d    [N_BR];
    logic [N_BR-1:0]       br_ready;
    logic [N_BR-1:0]       br_valid;
    logic [N_BR-1:0]       pop;
    logic                  push;
    logic [CNT_WIDTH-1:0]  cnt_max;

    assign br_ready = {data_out_v_ready, data_out_k_ready, data_out_q_ready};

    // Per-branch valid is simply "this branch still has unread tiles".
    for (genvar gi = 0; gi < N_BR; gi++) begin : g_branch
        assign br_valid[gi] = (cnt_q[gi] != '0);
        assign pop[gi]      = br_valid[gi] && br_ready[gi];
    end

    // Occupancy tracks the slowest branch; the buffer is full when that branch is.
    always_comb begin
        cnt_max = cnt_q[0];
        for (int b = 1; b < N_BR; b++) begin
            if (cnt_q[b] > cnt_max) cnt_max = cnt_q[b];
        end
    end

    // Ready comes from registered state only: a pop this cycle frees space next cycle.
    assign data_in_ready = !rst && (cnt_max < FULL_CNT);
    assign push          = data_in_valid && data_in_ready;
    assign occupancy     = cnt_max;

    // Next-state for write pointer, read pointers and per-branch counts.
    always_comb begin
        wr_ptr_d = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        for (int b = 0; b < N_BR; b++) begin
            rd_ptr_d[b] = pop[b] ? ptr_next(rd_ptr_q[b]) : rd_ptr_q[b];
            cnt_d[b]    = cnt_q[b];
            if (push && !pop[b]) begin
                cnt_d[b] = cnt_q[b] + 1'b1;
            end else if (!push && pop[b]) begin
                cnt_d[b] = cnt_q[b] - 1'b1;
            end
        end
    end

    // Pointer and count registers; reset discards every buffered tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            for (int b = 0; b < N_BR; b++) begin
                rd_ptr_q[b] <= '0;
                cnt_q[b]    <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            for (int b = 0; b < N_BR; b++) begin
                rd_ptr_q[b] <= rd_ptr_d[b];
                cnt_q[b]    <= cnt_d[b];
            end
        end
    end

    // Tile storage; entries are cleared on reset so outputs read back as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                for (int e = 0; e < N_ELEM; e++) begin
                    mem_q[d][e] <= '0;
                end
            end
        end else if (push) begin
            for (int e = 0; e < N_ELEM; e++) begin
                mem_q[wr_ptr_q][e] <= data_in[e];
            end
        end
    end

    // Branch outputs read straight from storage; the full rule keeps an unread
    // entry from being overwritten, so a stalled branch sees stable data.
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_out
        assign data_out_q[gi] = mem_q[rd_ptr_q[0]][gi];
        assign data_out_k[gi] = mem_q[rd_ptr_q[1]][gi];
        assign data_out_v[gi] = mem_q[rd_ptr_q[2]][gi];
    end

    assign data_out_q_valid = br_valid[0];
    assign data_out_k_valid = br_valid[1];
    assign data_out_v_valid = br_valid[2];

endmodule

// File: tb/tb_fixed_att_input_fork.sv
// Directed bench for fixed_att_input_fork (DEPTH = 6).
module tb_fixed_att_input_fork;

    localparam int DW    = 8;
    localparam int NE    = 9;
    localparam int DEPTH = 6;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic [DW-1:0] din [NE];
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] dq [NE];
    logic [DW-1:0] dk [NE];
    logic [DW-1:0] dv [NE];
    logic          q_valid, k_valid, v_valid;
    logic          q_ready, k_ready, v_ready;
    logic [CW-1:0] occ;

    int vectors    = 0;
    int miscompares = 0;

    fixed_att_input_fork #(
        .DATA_WIDTH(DW), .IN_PARALLELISM(3), .IN_SIZE(3), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(din_valid), .data_in_ready(din_ready),
        .data_out_q(dq), .data_out_q_valid(q_valid), .data_out_q_ready(q_ready),
        .data_out_k(dk), .data_out_k_valid(k_valid), .data_out_k_ready(k_ready),
        .data_out_v(dv), .data_out_v_valid(v_valid), .data_out_v_ready(v_ready),
        .occupancy(occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NE*DW-1:0] q_pk, k_pk, v_pk;
    always_comb begin
        for (int i = 0; i < NE; i++) begin
            q_pk[i*DW +: DW] = dq[i];
            k_pk[i*DW +: DW] = dk[i];
            v_pk[i*DW +: DW] = dv[i];
        end
    end

    function automatic logic [NE*DW-1:0] fill(input int v);
        logic [NE*DW-1:0] r;
        for (int i = 0; i < NE; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [NE*DW-1:0] obs, input logic [NE*DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_fill(input int v);
        for (int i = 0; i < NE; i++) din[i] = DW'(v);
    endtask

    // Advance one clock and move to the drive point just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int expb [3];
        int cyc;
        logic pushed;

        rst = 1'b1; din_valid = 1'b0; set_fill(0);
        q_ready = 1'b0; k_ready = 1'b0; v_ready = 1'b0;

        // ---- Reset state ----
        #2;
        chk("rst_ready", 72'(din_ready), 72'(0));
        chk("rst_valids", 72'({v_valid, k_valid, q_valid}), 72'(0));
        chk("rst_occ", 72'(occ), 72'(0));
        chk("rst_data_q", q_pk, 72'(0));
        tick(); tick();
        rst = 1'b0;

        // ---- Test 1: single tile, all branches ready ----
        for (int i = 0; i < NE; i++) din[i] = DW'(i);
        din_valid = 1'b1; q_ready = 1'b1; k_ready = 1'b1; v_ready = 1'b1;
        #2;
        chk("t1_ready", 72'(din_ready), 72'(1));
        chk("t1_occ0", 72'(occ), 72'(0));
        tick();
        din_valid = 1'b0;
        #2;
        chk("t1_valids", 72'({v_valid, k_valid, q_valid}), 72'(3'b111));
        chk("t1_data_q", q_pk, 72'h08_07_06_05_04_03_02_01_00);
        chk("t1_data_k", k_pk, 72'h08_07_06_05_04_03_02_01_00);
        chk("t1_data_v", v_pk, 72'h08_07_06_05_04_03_02_01_00);
        chk("t1_occ1", 72'(occ), 72'(1));
        tick();
        #2;
        chk("t1_valids_low", 72'({v_valid, k_valid, q_valid}), 72'(0));
        chk("t1_occ2", 72'(occ), 72'(0));
        tick();

        // ---- Test 2: V stalled, stream 6 tiles ----
        v_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            din_valid = 1'b1; set_fill(c);
            #2;
            chk("t2_ready", 72'(din_ready), 72'(1));
            if (c > 0) begin
                chk("t2_q", q_pk, fill(c - 1));
                chk("t2_k", k_pk, fill(c - 1));
            end
            tick();
        end
        din_valid = 1'b1; set_fill(99);
        #2;
        chk("t2_full_ready", 72'(din_ready), 72'(0));
        chk("t2_full_occ", 72'(occ), 72'(6));
        chk("t2_q_last", q_pk, fill(5));
        chk("t2_v_first", v_pk, fill(0));
        v_ready = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int j = 1; j < 6; j++) begin
            #2;
            if (j == 1) chk("t2_ready_back", 72'(din_ready), 72'(1));
            chk("t2_v_valid", 72'(v_valid), 72'(1));
            chk("t2_v", v_pk, fill(j));
            tick();
        end
        #2;
        chk("t2_drained", 72'({v_valid, k_valid, q_valid}), 72'(0));
        chk("t2_occ_end", 72'(occ), 72'(0));
        tick();

        // ---- Test 3: 12 tiles, random independent readies ----
        sent = 0; expb[0] = 0; expb[1] = 0; expb[2] = 0; cyc = 0;
        while (cyc < 600 && !(expb[0] == 12 && expb[1] == 12 && expb[2] == 12)) begin
            din_valid = (sent < 12); set_fill(100 + sent);
            q_ready = 1'($urandom_range(0, 1));
            k_ready = 1'($urandom_range(0, 1));
            v_ready = 1'($urandom_range(0, 1));
            #2;
            chk("t3_occ_bound", 72'(occ <= CW'(DEPTH)), 72'(1));
            if (q_valid && q_ready) begin chk("t3_q", q_pk, fill(100 + expb[0])); expb[0]++; end
            if (k_valid && k_ready) begin chk("t3_k", k_pk, fill(100 + expb[1])); expb[1]++; end
            if (v_valid && v_ready) begin chk("t3_v", v_pk, fill(100 + expb[2])); expb[2]++; end
            pushed = din_valid && din_ready;
            tick();
            if (pushed) sent++;
            cyc++;
        end
        din_valid = 1'b0; q_ready = 1'b1; k_ready = 1'b1; v_ready = 1'b1;
        chk("t3_done_q", 72'(expb[0]), 72'(12));
        chk("t3_done_k", 72'(expb[1]), 72'(12));
        chk("t3_done_v", 72'(expb[2]), 72'(12));
        tick();
        #2;
        chk("t3_empty", 72'({v_valid, k_valid, q_valid}), 72'(0));
        tick();

        // ---- Test 4: full, then pop and push offered in the same cycle ----
        v_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            din_valid = 1'b1; set_fill(20 + c);
            tick();
        end
        din_valid = 1'b1; set_fill(26); v_ready = 1'b1;
        #2;
        chk("t4_ready_full", 72'(din_ready), 72'(0));
        chk("t4_v_head", v_pk, fill(20));
        tick();
        v_ready = 1'b0;
        #2;
        chk("t4_ready_next", 72'(din_ready), 72'(1));
        chk("t4_occ5", 72'(occ), 72'(5));
        chk("t4_v_head2", v_pk, fill(21));
        tick();
        din_valid = 1'b0;
        #2;
        chk("t4_ready_refull", 72'(din_ready), 72'(0));
        chk("t4_occ6", 72'(occ), 72'(6));
        v_ready = 1'b1;
        for (int j = 21; j < 27; j++) begin
            chk("t4_v_order", v_pk, fill(j));
            tick();
            #2;
        end
        chk("t4_empty", 72'({v_valid, k_valid, q_valid}), 72'(0));
        tick();

        // ---- Test 5: K held with ready low while pushes continue ----
        k_ready = 1'b0; q_ready = 1'b1; v_ready = 1'b1;
        din_valid = 1'b1; set_fill(40);
        tick();
        for (int c = 1; c <= 10; c++) begin
            set_fill(40 + c);
            #2;
            chk("t5_k_valid", 72'(k_valid), 72'(1));
            chk("t5_k_hold", k_pk, fill(40));
            tick();
        end
        din_valid = 1'b0; k_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #2;
            chk("t5_k_order", k_pk, fill(40 + j));
            tick();
        end
        #2;
        chk("t5_empty", 72'({v_valid, k_valid, q_valid}), 72'(0));
        tick();

        // ---- Test 6: reset with 3 tiles buffered ----
        q_ready = 1'b0; k_ready = 1'b0; v_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            din_valid = 1'b1; set_fill(60 + c);
            tick();
        end
        din_valid = 1'b0;
        #2;
        chk("t6_pre_occ", 72'(occ), 72'(3));
        rst = 1'b1;
        #1;
        chk("t6_async_valids", 72'({v_valid, k_valid, q_valid}), 72'(0));
        chk("t6_async_ready", 72'(din_ready), 72'(0));
        tick(); tick();
        rst = 1'b0; q_ready = 1'b1; k_ready = 1'b1; v_ready = 1'b1;
        #2;
        chk("t6_ready", 72'(din_ready), 72'(1));
        chk("t6_occ", 72'(occ), 72'(0));
        for (int c = 0; c < 5; c++) begin
            chk("t6_no_stale", 72'({v_valid, k_valid, q_valid}), 72'(0));
            tick();
            #2;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
